// File: rtl/if_fetch_if.sv
// ROM fetch bus: request/grant for addresses, in-order rvalid for returned words.
interface if_fetch_if;
   logic        rom_req_o;
   logic [31:0] rom_addr_o;
   logic        rom_gnt_i;
   logic        rom_rvalid_i;
   logic [31:0] rom_rdata_i;

   modport master (
      output rom_req_o,
      output rom_addr_o,
      input  rom_gnt_i,
      input  rom_rvalid_i,
      input  rom_rdata_i
   );

   modport slave (
      input  rom_req_o,
      input  rom_addr_o,
      output rom_gnt_i,
      output rom_rvalid_i,
      output rom_rdata_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch unit: PC owner, ROM request issue, in-flight address tracking,
// stale-response discard after redirects and an in-order prefetch FIFO feeding if_id.

// Invariant checker for the fetch bookkeeping counters.
module if_fetch_chk #(
   parameter int unsigned CW         = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   input logic [CW-1:0] i_outstanding,
   input logic [CW-1:0] i_discard,
   input logic [CW-1:0] i_count
);
   localparam int unsigned OW = CW + 1;
   localparam logic [OW-1:0] L_DEPTH = OW'(FIFO_DEPTH);

   // In-flight requests plus buffered words never exceed the prefetch capacity.
   a_occupancy: assert property (@(posedge clk) disable iff (rst)
      (({1'b0, i_outstanding} + {1'b0, i_count}) <= L_DEPTH));

   // Words to be dropped are always a subset of the words still in flight.
   a_discard: assert property (@(posedge clk) disable iff (rst)
      (i_discard <= i_outstanding));
endmodule

module if_fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   if_fetch_if.master  rom,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = CW + 1;

   localparam logic [CW-1:0] C_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] C_ZERO  = '0;
   localparam logic [PW-1:0] P_ONE   = PW'(1'b1);
   localparam logic [PW-1:0] P_ZERO  = '0;
   localparam logic [OW-1:0] O_DEPTH = OW'(FIFO_DEPTH);

   // Architectural state
   logic [31:0]   r_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_count;

   // Address queue: one entry per non-discarded request in flight
   logic [31:0]   r_aq_mem [FIFO_DEPTH];
   logic [PW-1:0] r_aq_wr;
   logic [PW-1:0] r_aq_rd;

   // Prefetch FIFO of {addr, inst}
   logic [31:0]   r_fifo_addr [FIFO_DEPTH];
   logic [31:0]   r_fifo_inst [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;

   // Per-cycle decode
   logic [OW-1:0] w_occupancy;
   logic          w_req;
   logic          w_xfer;
   logic          w_rsp;
   logic          w_rsp_drop;
   logic          w_rsp_keep;
   logic          w_head_valid;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_jump_target;
   logic [CW-1:0] w_out_nxt;
   logic [CW-1:0] w_discard_nxt;
   logic [CW-1:0] w_count_nxt;

   // Issue throttle uses registered counts only: a slot freed by a pop this cycle
   // becomes visible to the request logic one cycle later.
   assign w_occupancy   = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_req         = ~rst & ~jump_flag_i & (w_occupancy < O_DEPTH);
   assign w_xfer        = w_req & rom.rom_gnt_i;
   // A response with nothing outstanding is a bus protocol error and is ignored.
   assign w_rsp         = rom.rom_rvalid_i & (r_outstanding != C_ZERO);
   assign w_rsp_drop    = w_rsp & (r_discard != C_ZERO);
   assign w_rsp_keep    = w_rsp & (r_discard == C_ZERO);
   assign w_head_valid  = (r_count != C_ZERO);
   assign w_push        = w_rsp_keep & ~jump_flag_i;
   assign w_pop         = w_head_valid & ~hold_flag_i & ~jump_flag_i;
   assign w_jump_target = jump_addr_i & 32'hFFFF_FFFC;

   assign rom.rom_req_o  = w_req;
   assign rom.rom_addr_o = r_pc;

   // Next values of the in-flight, discard and FIFO occupancy counters.
   always_comb begin
      w_out_nxt     = r_outstanding;
      w_discard_nxt = r_discard;
      w_count_nxt   = r_count;

      if (w_xfer && !w_rsp) begin
         w_out_nxt = r_outstanding + C_ONE;
      end else if (!w_xfer && w_rsp) begin
         w_out_nxt = r_outstanding - C_ONE;
      end else begin
         w_out_nxt = r_outstanding;
      end

      // On a redirect every request still in flight turns stale; no grant can
      // happen in the redirect cycle, so w_out_nxt is exactly that set.
      if (jump_flag_i) begin
         w_discard_nxt = w_out_nxt;
      end else if (w_rsp_drop) begin
         w_discard_nxt = r_discard - C_ONE;
      end else begin
         w_discard_nxt = r_discard;
      end

      if (jump_flag_i) begin
         w_count_nxt = C_ZERO;
      end else if (w_push && !w_pop) begin
         w_count_nxt = r_count + C_ONE;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - C_ONE;
      end else begin
         w_count_nxt = r_count;
      end
   end

   // PC, counters and queue pointers; reset and redirect flush everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_ADDR;
         r_outstanding <= C_ZERO;
         r_discard     <= C_ZERO;
         r_count       <= C_ZERO;
         r_aq_wr       <= P_ZERO;
         r_aq_rd       <= P_ZERO;
         r_wr_ptr      <= P_ZERO;
         r_rd_ptr      <= P_ZERO;
      end else begin
         r_outstanding <= w_out_nxt;
         r_discard     <= w_discard_nxt;
         r_count       <= w_count_nxt;
         if (jump_flag_i) begin
            r_pc     <= w_jump_target;
            r_aq_wr  <= P_ZERO;
            r_aq_rd  <= P_ZERO;
            r_wr_ptr <= P_ZERO;
            r_rd_ptr <= P_ZERO;
         end else begin
            if (w_xfer) begin
               r_pc    <= r_pc + 32'd4;
               r_aq_wr <= r_aq_wr + P_ONE;
            end
            if (w_rsp_keep) begin
               r_aq_rd <= r_aq_rd + P_ONE;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + P_ONE;
            end
         end
      end
   end

   // Remember the address of every granted request until its word returns.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_aq_mem[r_aq_wr] <= r_pc;
      end
   end

   // Write a returned word with its request address into the FIFO tail.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= r_aq_mem[r_aq_rd];
         r_fifo_inst[r_wr_ptr] <= rom.rom_rdata_i;
      end
   end

   // Present the FIFO head, or a NOP at address 0 when nothing is buffered.
   always_comb begin
      inst_valid_o = 1'b0;
      inst_o       = INST_NOP;
      inst_addr_o  = 32'h0000_0000;
      if (w_head_valid) begin
         inst_valid_o = 1'b1;
         inst_o       = r_fifo_inst[r_rd_ptr];
         inst_addr_o  = r_fifo_addr[r_rd_ptr];
      end else begin
         inst_valid_o = 1'b0;
         inst_o       = INST_NOP;
         inst_addr_o  = 32'h0000_0000;
      end
   end

   if_fetch_chk #(
      .CW         (CW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_chk (
      .clk           (clk),
      .rst           (rst),
      .i_outstanding (r_outstanding),
      .i_discard     (r_discard),
      .i_count       (r_count)
   );
endmodule
